// File: rtl/status_flag_writer_if.sv
// status_flag_writer_if: EXE command, operands and control in; ALU result and NZCV status out
interface status_flag_writer_if #(
    parameter int data_w = 32,
    parameter int cmd_w  = 4
);
    logic [cmd_w-1:0]  exe_cmd;
    logic [data_w-1:0] val1;
    logic [data_w-1:0] val2;
    logic              s_en;
    logic              freeze;
    logic              flush;
    logic              exc_entry;
    logic              exc_return;
    logic [data_w-1:0] alu_res;
    logic [3:0]        status_regs;
    logic [3:0]        status_fwd;
    logic              shadow_valid;
    logic              nest_err;
    modport master(
        output exe_cmd, val1, val2, s_en, freeze, flush, exc_entry, exc_return,
        input  alu_res, status_regs, status_fwd, shadow_valid, nest_err
    );
    modport slave(
        input  exe_cmd, val1, val2, s_en, freeze, flush, exc_entry, exc_return,
        output alu_res, status_regs, status_fwd, shadow_valid, nest_err
    );
endinterface

// File: rtl/status_flag_writer.sv
// status_flag_writer: EXE ALU with NZCV commit and one exception shadow; FLAG_BYPASS_EN forwards next-state flags
module status_flag_writer #(
    parameter int data_w = 32,
    parameter int cmd_w  = 4
) (
    input logic                 clk,
    input logic                 rst,
    status_flag_writer_if.slave sf
);
    localparam int m = data_w - 1;
    typedef logic [cmd_w-1:0] cmd_t;
    localparam cmd_t c_mov = cmd_t'(4'b0001);
    localparam cmd_t c_mvn = cmd_t'(4'b1001);
    localparam cmd_t c_add = cmd_t'(4'b0010);
    localparam cmd_t c_adc = cmd_t'(4'b0011);
    localparam cmd_t c_sub = cmd_t'(4'b0100);
    localparam cmd_t c_sbc = cmd_t'(4'b0101);
    localparam cmd_t c_and = cmd_t'(4'b0110);
    localparam cmd_t c_orr = cmd_t'(4'b0111);
    localparam cmd_t c_eor = cmd_t'(4'b1000);

    logic [3:0]        r_status;
    logic [3:0]        r_shadow;
    logic              r_shadow_valid;
    logic              r_nest_err;
    logic [data_w:0]   w_a;
    logic [data_w:0]   w_b;
    logic [data_w:0]   w_s;
    logic [data_w-1:0] w_r;
    logic              w_def;
    logic              w_add;
    logic              w_sub;
    logic              w_c;
    logic              w_v;
    logic [3:0]        w_cand;
    logic              w_commit;
    logic              w_ret;
    logic              w_ent;
    logic [3:0]        w_next;

    always_comb begin
        w_a   = {1'b0, sf.val1};
        w_b   = {1'b0, sf.val2};
        w_s   = '0;
        w_r   = '0;
        w_def = 1'b1;
        w_add = 1'b0;
        w_sub = 1'b0;
        case (sf.exe_cmd)
            c_mov: w_r = sf.val2;
            c_mvn: w_r = ~sf.val2;
            c_and: w_r = sf.val1 & sf.val2;
            c_orr: w_r = sf.val1 | sf.val2;
            c_eor: w_r = sf.val1 ^ sf.val2;
            c_add, c_adc: begin
                w_add = 1'b1;
                w_s   = w_a + w_b + (data_w + 1)'(sf.exe_cmd == c_adc && r_status[1]);
                w_r   = w_s[m:0];
            end
            c_sub, c_sbc: begin
                w_sub = 1'b1;
                w_s   = w_a - w_b - (data_w + 1)'(sf.exe_cmd == c_sbc && !r_status[1]);
                w_r   = w_s[m:0];
            end
            default: w_def = 1'b0;
        endcase
        w_c    = (w_add | w_sub) ? w_s[data_w] : r_status[1];
        w_v    = w_add ? (sf.val1[m] == sf.val2[m] && w_r[m] != sf.val1[m]) :
                 w_sub ? (sf.val1[m] != sf.val2[m] && w_r[m] != sf.val1[m]) : r_status[0];
        w_cand = w_def ? {w_r[m], w_r == '0, w_c, w_v} : r_status;
    end

    // exc_return outranks both exc_entry and the commit; an empty-shadow return changes nothing but nest_err
    assign w_commit = sf.s_en & ~sf.freeze & ~sf.flush & w_def;
    assign w_ret    = sf.exc_return & ~sf.freeze;
    assign w_ent    = sf.exc_entry & ~sf.exc_return & ~sf.freeze;
    assign w_next   = w_ret ? (r_shadow_valid ? r_shadow : r_status) : w_commit ? w_cand : r_status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status       <= '0;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_nest_err     <= 1'b0;
        end else begin
            r_status       <= w_next;
            r_shadow       <= (w_ent & ~r_shadow_valid) ? r_status : r_shadow;
            r_shadow_valid <= w_ret ? 1'b0 : w_ent ? 1'b1 : r_shadow_valid;
            r_nest_err     <= r_nest_err | (w_ret & ~r_shadow_valid) | (w_ent & r_shadow_valid);
        end
    end

    assign sf.alu_res      = w_r;
    assign sf.status_regs  = r_status;
    assign sf.shadow_valid = r_shadow_valid;
    assign sf.nest_err     = r_nest_err;
`ifdef FLAG_BYPASS_EN
    assign sf.status_fwd   = w_next;
`else
    assign sf.status_fwd   = r_status;
`endif
endmodule

// File: tb/tb_status_flag_writer.sv
// tb_status_flag_writer: directed vectors against an arithmetic reference model of the NZCV writer
module tb_status_flag_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] res_seen;
    logic [3:0]  fwd_seen;
    logic [3:0]  m_status, m_shadow;
    logic        m_valid, m_err;
    logic [31:0] mr, cr;
    logic [3:0]  mf, cf;
    logic        md, cd;
    logic [67:0] tbl [6];

    status_flag_writer_if #(.data_w(32), .cmd_w(4)) sf();
    status_flag_writer #(.data_w(32), .cmd_w(4)) dut (.clk(clk), .rst(rst), .sf(sf));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags from plain integer arithmetic: carry/borrow by magnitude, overflow by signed range
    function automatic void alu_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] f, output logic [31:0] res, output logic [3:0] fl,
                                      output logic def);
        longint ua = a, ub = b, sa = $signed(a), sb = $signed(b), cin = f[1], us = 0, ss = 0, bor = 0;
        logic c = f[1], v = f[0];
        def = 1'b1;
        res = '0;
        case (cmd)
            4'h1: res = b;
            4'h9: res = ~b;
            4'h6: res = a & b;
            4'h7: res = a | b;
            4'h8: res = a ^ b;
            4'h2, 4'h3: begin
                if (cmd == 4'h2) cin = 0;
                us = ua + ub + cin;
                ss = sa + sb + cin;
                res = us[31:0];
                c = us > 64'sd4294967295;
                v = ss > 64'sd2147483647 || ss < -64'sd2147483648;
            end
            4'h4, 4'h5: begin
                bor = (cmd == 4'h5 && !f[1]) ? 1 : 0;
                us = ua - ub - bor;
                ss = sa - sb - bor;
                res = us[31:0];
                c = us < 0;
                v = ss > 64'sd2147483647 || ss < -64'sd2147483648;
            end
            default: def = 1'b0;
        endcase
        fl = def ? {res[31], res == 32'd0, c, v} : f;
    endfunction

    function automatic logic [3:0] next_status(input logic [3:0] cand, input logic def);
        if (sf.exc_return && !sf.freeze) return m_valid ? m_shadow : m_status;
        return (sf.s_en && !sf.freeze && !sf.flush && def) ? cand : m_status;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_status <= '0;
            m_shadow <= '0;
            m_valid  <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            alu_model(sf.exe_cmd, sf.val1, sf.val2, m_status, mr, mf, md);
            m_status <= next_status(mf, md);
            if (sf.exc_return && !sf.freeze) begin
                if (!m_valid) m_err <= 1'b1;
                m_valid <= 1'b0;
            end else if (sf.exc_entry && !sf.freeze) begin
                if (m_valid) m_err <= 1'b1;
                else begin
                    m_shadow <= m_status;
                    m_valid  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            alu_model(sf.exe_cmd, sf.val1, sf.val2, m_status, cr, cf, cd);
            chk("cyc_alu_res", sf.alu_res, cr);
            chk("cyc_status_regs", 32'(sf.status_regs), 32'(m_status));
`ifdef FLAG_BYPASS_EN
            chk("cyc_status_fwd", 32'(sf.status_fwd), 32'(next_status(cf, cd)));
`else
            chk("cyc_status_fwd", 32'(sf.status_fwd), 32'(m_status));
`endif
            chk("cyc_shadow_valid", 32'(sf.shadow_valid), 32'(m_valid));
            chk("cyc_nest_err", 32'(sf.nest_err), 32'(m_err));
        end
    end

    task automatic step(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic fz, input logic fl, input logic en, input logic rt);
        sf.exe_cmd = cmd;
        sf.val1 = a;
        sf.val2 = b;
        sf.s_en = s;
        sf.freeze = fz;
        sf.flush = fl;
        sf.exc_entry = en;
        sf.exc_return = rt;
        #2;
        res_seen = sf.alu_res;
        fwd_seen = sf.status_fwd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl = '{{4'h3, 32'h7FFFFFFF, 32'h7FFFFFFF}, {4'h5, 32'h80000000, 32'h00000001},
                {4'h7, 32'h00000000, 32'h00000000}, {4'h8, 32'hAAAA5555, 32'hAAAA5555},
                {4'h1, 32'h00000000, 32'h80000000}, {4'h9, 32'h00000000, 32'h00000000}};
        step(4'h0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("reset_status", 32'(sf.status_regs), 32'h0);
        chk("reset_shadow_valid", 32'(sf.shadow_valid), 32'h0);
        chk("reset_nest_err", 32'(sf.nest_err), 32'h0);
        step(4'h2, 32'h7FFFFFFF, 32'h1, 1, 0, 0, 0, 0);
        chk("add_ovf_res", res_seen, 32'h80000000);
        chk("add_ovf_flags", 32'(sf.status_regs), 32'b1001);
        step(4'h2, 32'h1, 32'h1, 0, 0, 0, 0, 0);
        chk("add_no_s_hold", 32'(sf.status_regs), 32'b1001);
        step(4'h4, 32'h5, 32'h5, 1, 0, 0, 0, 0);
        chk("sub_zero_flags", 32'(sf.status_regs), 32'b0100);
        step(4'h4, 32'h3, 32'h5, 1, 0, 0, 0, 0);
        chk("sub_neg_res", res_seen, 32'hFFFFFFFE);
        chk("sub_neg_flags", 32'(sf.status_regs), 32'b1010);
        step(4'h2, 32'h80000000, 32'h80000001, 1, 0, 0, 0, 0);
        chk("preset_0011", 32'(sf.status_regs), 32'b0011);
        step(4'h6, 32'hF0F0F0F0, 32'h0F0F0F0F, 1, 1, 0, 0, 0);
        chk("and_freeze_hold", 32'(sf.status_regs), 32'b0011);
        step(4'h6, 32'hF0F0F0F0, 32'h0F0F0F0F, 1, 0, 1, 0, 0);
        chk("and_flush_hold", 32'(sf.status_regs), 32'b0011);
        step(4'h6, 32'hF0F0F0F0, 32'h0F0F0F0F, 1, 0, 0, 0, 0);
        chk("and_keeps_cv", 32'(sf.status_regs), 32'b0111);
        step(4'h2, 32'h80000000, 32'h0, 1, 0, 0, 0, 0);
        chk("preset_1000", 32'(sf.status_regs), 32'b1000);
        step(4'h2, 32'h1, 32'h1, 1, 0, 0, 1, 0);
        chk("entry_commit_flags", 32'(sf.status_regs), 32'b0000);
        chk("entry_valid", 32'(sf.shadow_valid), 32'h1);
        step(4'h4, 32'h3, 32'h5, 1, 0, 0, 0, 1);
        chk("return_restores", 32'(sf.status_regs), 32'b1000);
        chk("return_clears_valid", 32'(sf.shadow_valid), 32'h0);
        step(4'h0, 0, 0, 0, 0, 0, 0, 1);
        chk("empty_return_err", 32'(sf.nest_err), 32'h1);
        chk("empty_return_hold", 32'(sf.status_regs), 32'b1000);
        step(4'hF, 32'h5, 32'h5, 1, 0, 0, 0, 0);
        chk("undef_res", res_seen, 32'h0);
        chk("undef_hold", 32'(sf.status_regs), 32'b1000);
        step(4'h2, 32'hFFFFFFFF, 32'h1, 1, 0, 0, 0, 0);
`ifdef FLAG_BYPASS_EN
        chk("fwd_same_cycle", 32'(fwd_seen), 32'b0110);
`else
        chk("fwd_old_value", 32'(fwd_seen), 32'b1000);
`endif
        chk("add_wrap_flags", 32'(sf.status_regs), 32'b0110);
        step(4'h3, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 0, 0);
        chk("adc_carry_in_res", res_seen, 32'h0);
        chk("adc_carry_in_flags", 32'(sf.status_regs), 32'b0110);
        step(4'h5, 32'h5, 32'h3, 1, 0, 0, 0, 0);
        chk("sbc_no_borrow_res", res_seen, 32'h2);
        chk("sbc_no_borrow_flags", 32'(sf.status_regs), 32'b0000);
        foreach (tbl[i]) step(tbl[i][67:64], tbl[i][63:32], tbl[i][31:0], 1, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_status", 32'(sf.status_regs), 32'h0);
        chk("async_rst_valid", 32'(sf.shadow_valid), 32'h0);
        chk("async_rst_err", 32'(sf.nest_err), 32'h0);
        #1 rst = 1'b0;
        step(4'h0, 0, 0, 0, 0, 0, 1, 0);
        chk("entry_after_rst_valid", 32'(sf.shadow_valid), 32'h1);
        chk("entry_after_rst_err", 32'(sf.nest_err), 32'h0);
        step(4'h0, 0, 0, 0, 0, 0, 1, 0);
        chk("nested_entry_err", 32'(sf.nest_err), 32'h1);
        step(4'h0, 0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/status_flag_writer.md
Name: status_flag_writer

Overview:
- Producer side of the NZCV status interface consumed by the condition-check logic in ID.
- Sits in EXE and computes the 32-bit ALU result and the candidate flags from the execute command.
- Commits the flags into the architectural status register when the instruction has S set and is neither frozen nor flushed.
- Holds one exception shadow copy: saved on exception entry, restored on exception return.

Parameters:
- data_w, 32, operand/result width (flag logic uses bit data_w-1 as sign).
- cmd_w, 4, execute command width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- exe_cmd  input  cmd_w  0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; others: result 0, no flag change
- val1  input  data_w  first operand
- val2  input  data_w  second operand
- s_en  input  1  instruction requests flag update
- freeze  input  1  pipeline stall; blocks any commit this cycle
- flush  input  1  squash EXE instruction; blocks flag commit
- exc_entry  input  1  save status into shadow
- exc_return  input  1  restore status from shadow
- alu_res  output  data_w  combinational result
- status_regs  output  4  registered {N,Z,C,V}, feeds condition check
- status_fwd  output  4  flags visible to a same-cycle reader (see Optional Feature)
- shadow_valid  output  1  shadow holds a saved value
- nest_err  output  1  sticky: illegal entry/return sequence seen

Behaviour:
- Reset (async): status_regs=0000, shadow=0000, shadow_valid=0, nest_err=0. alu_res follows its inputs (combinational).
- Arithmetic uses a 33-bit extension {1'b0,x}; Cold = status_regs C.
- ADD: a+b. ADC: a+b+Cold. C = bit 32 of the sum.
- SUB: a-b. SBC: a-b-~Cold. C = bit 32 of the difference (borrow).
- V, add forms: a[31]==b[31] && r[31]!=a[31]. V, sub forms: a[31]!=b[31] && r[31]!=a[31].
- MOV: r=b. MVN: r=~b. AND/ORR/EOR: bitwise. For these, N and Z are updated and C, V keep their old values.
- N = r[31]; Z = (r==0), for all defined commands.
- Undefined exe_cmd: alu_res=0; candidate flags equal the old flags.
- commit = s_en & ~freeze & ~flush & cmd defined. On commit, status_regs <= candidate at the next edge. Latency is 1 cycle; the ID reader sees the new flags the cycle after commit.
- Without commit, status_regs holds.
- Priority per edge, highest first: rst > exc_return > exc_entry/commit. freeze also blocks exc_entry and exc_return.
- exc_entry & ~freeze:
  - If shadow_valid=0: shadow <= status_regs (pre-update value) and shadow_valid <= 1. A simultaneous commit still updates status_regs.
  - If shadow_valid=1: shadow is kept and nest_err <= 1.
- exc_return & ~freeze:
  - If shadow_valid=1: status_regs <= shadow, shadow_valid <= 0. Any simultaneous commit is discarded.
  - If shadow_valid=0: status_regs is unchanged and nest_err <= 1.
- exc_entry and exc_return together: exc_return wins; exc_entry is ignored.
- nest_err clears only on rst.
- rst asserted mid-operation returns every register to its reset value immediately, regardless of clock.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: status_fwd is the next-state value of status_regs, combinationally. That is the candidate flags on commit, the shadow on a valid return, and status_regs otherwise. This lets a same-cycle condition check avoid a 1-cycle S-hazard stall.
- Undefined: status_fwd = status_regs. The hazard unit must stall the dependent instruction one cycle.

Test Plan:
- Reset mid-run: pulse rst asynchronously between edges -> status_regs=0000, shadow_valid=0, nest_err=0 before the next edge.
- ADD 0x7FFFFFFF+0x00000001, s_en=1 -> alu_res=0x80000000; status_regs=1001 after one edge. Repeat with s_en=0 -> status_regs unchanged.
- SUB 5-5 with s_en=1 -> status_regs=0100. SUB 3-5 -> alu_res=0xFFFFFFFE, status_regs=1010.
- Preset status 0011, then AND 0xF0F0F0F0&0x0F0F0F0F with s_en=1 -> status_regs=0111 (C, V preserved). Same with freeze=1 or flush=1 -> stays 0011.
- Status 1000: exc_entry plus ADD 1+1 commit -> shadow=1000, status 0000. Then exc_return together with a SUB commit -> status 1000, shadow_valid=0. A second exc_return -> nest_err=1, status unchanged.
- With FLAG_BYPASS_EN: ADD 0xFFFFFFFF+1, s_en=1 -> status_fwd=0110 in the same cycle. Without the macro -> status_fwd shows the old value until the edge.
